// File: rtl/memory_dma.sv
// Byte-stream <-> 16-bit memory DMA engine.
// Packs/unpacks bytes into aligned halfword transactions with byte masks for odd edges.
module memory_dma #(
    parameter int unsigned LENGTH_WIDTH = 27
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    direction,
    input  logic [31:0]             starting_address,
    input  logic [LENGTH_WIDTH-1:0] transfer_length,
    output logic                    busy,
    input  logic                    rx_empty,
    output logic                    rx_read,
    input  logic [7:0]              rx_rdata,
    input  logic                    tx_full,
    output logic                    tx_write,
    output logic [7:0]              tx_wdata,
    output logic                    mem_request,
    input  logic                    mem_ack,
    output logic                    mem_write,
    output logic [31:0]             mem_address,
    output logic [1:0]              mem_wmask,
    output logic [15:0]             mem_wdata,
    input  logic [15:0]             mem_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic [2:0] {
        IDLE,
        GATHER,
        REQUEST,
        WAIT_ACK,
        EMIT
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [LENGTH_WIDTH-1:0] remain_q, remain_d;
    logic                    dir_q, dir_d;
    logic                    abort_q, abort_d;
    logic                    bidx_q, bidx_d;
    logic [DW-1:0]           data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    mem_request_q, mem_request_d;
    logic                    mem_write_q, mem_write_d;
    logic [AW-1:0]           mem_address_q, mem_address_d;
    logic [1:0]              mem_wmask_q, mem_wmask_d;
    logic [DW-1:0]           mem_wdata_q, mem_wdata_d;
    logic                    rx_read_c, tx_write_c;

    // Shape of the current word: two bytes only when aligned with at least two remaining.
    logic                    two_byte_c;
    logic                    hi_lane_c;
    logic                    last_byte_c;
    logic [1:0]              word_mask_c;
    logic [AW-1:0]           addr_next_c;
    logic [LENGTH_WIDTH-1:0] remain_next_c;

    assign two_byte_c    = !addr_q[0] && (remain_q > LENGTH_WIDTH'(1));
    assign hi_lane_c     = !addr_q[0] && !bidx_q;
    assign last_byte_c   = !two_byte_c || bidx_q;
    assign word_mask_c   = two_byte_c ? 2'b11 : (addr_q[0] ? 2'b01 : 2'b10);
    assign addr_next_c   = addr_q + (two_byte_c ? AW'(2) : AW'(1));
    assign remain_next_c = remain_q - (two_byte_c ? LENGTH_WIDTH'(2) : LENGTH_WIDTH'(1));

    // Next-state and datapath decisions.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remain_d      = remain_q;
        dir_d         = dir_q;
        abort_d       = abort_q;
        bidx_d        = bidx_q;
        data_d        = data_q;
        busy_d        = 1'b0;
        mem_request_d = mem_request_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wmask_d   = mem_wmask_q;
        mem_wdata_d   = mem_wdata_q;
        rx_read_c     = 1'b0;
        tx_write_c    = 1'b0;

        case (state_q)
            IDLE: begin
                // busy_q also covers the one-cycle zero-length pulse, so start is ignored then too.
                if (start && !busy_q) begin
                    addr_d   = starting_address;
                    remain_d = transfer_length;
                    dir_d    = direction;
                    abort_d  = 1'b0;
                    bidx_d   = 1'b0;
                    data_d   = '0;
                    if (transfer_length == '0) begin
                        busy_d = 1'b1;
                    end else begin
                        state_d = direction ? REQUEST : GATHER;
                    end
                end
            end

            GATHER: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!rx_empty) begin
                    rx_read_c = 1'b1;
                    if (!bidx_q) begin
                        data_d = hi_lane_c ? {rx_rdata, BW'(0)} : {BW'(0), rx_rdata};
                    end else begin
                        data_d[BW-1:0] = rx_rdata;
                    end
                    if (last_byte_c) begin
                        bidx_d  = 1'b0;
                        state_d = REQUEST;
                    end else begin
                        bidx_d = 1'b1;
                    end
                end
            end

            REQUEST: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    mem_request_d = 1'b1;
                    mem_write_d   = !dir_q;
                    mem_address_d = {addr_q[AW-1:1], 1'b0};
                    mem_wmask_d   = dir_q ? 2'b11 : word_mask_c;
                    mem_wdata_d   = dir_q ? DW'(0) : data_q;
                    state_d       = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                // A stop here must still let the bus transaction complete.
                if (stop) begin
                    abort_d = 1'b1;
                end
                if (mem_ack) begin
                    mem_request_d = 1'b0;
                    mem_write_d   = 1'b0;
                    if (abort_q || stop) begin
                        state_d = IDLE;
                    end else if (dir_q) begin
                        data_d  = mem_rdata;
                        bidx_d  = 1'b0;
                        state_d = EMIT;
                    end else begin
                        addr_d   = addr_next_c;
                        remain_d = remain_next_c;
                        state_d  = (remain_next_c == '0) ? IDLE : GATHER;
                    end
                end
            end

            EMIT: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!tx_full) begin
                    tx_write_c = 1'b1;
                    if (last_byte_c) begin
                        addr_d   = addr_next_c;
                        remain_d = remain_next_c;
                        bidx_d   = 1'b0;
                        state_d  = (remain_next_c == '0) ? IDLE : REQUEST;
                    end else begin
                        bidx_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (state_d != IDLE) begin
            busy_d = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remain_q      <= '0;
            dir_q         <= 1'b0;
            abort_q       <= 1'b0;
            bidx_q        <= 1'b0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            mem_request_q <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wmask_q   <= 2'b00;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remain_q      <= remain_d;
            dir_q         <= dir_d;
            abort_q       <= abort_d;
            bidx_q        <= bidx_d;
            data_q        <= data_d;
            busy_q        <= busy_d;
            mem_request_q <= mem_request_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wmask_q   <= mem_wmask_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // FIFO strobes must react to empty/full in the same cycle.
    assign rx_read     = rx_read_c;
    assign tx_write    = tx_write_c;
    assign tx_wdata    = hi_lane_c ? data_q[DW-1:BW] : data_q[BW-1:0];
    assign busy        = busy_q;
    assign mem_request = mem_request_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wmask   = mem_wmask_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_memory_dma.sv
// Directed scoreboard bench for memory_dma: bench-side rx FIFO, tx sink and memory responder.
`timescale 1ns/1ps
module tb_memory_dma;

    localparam int unsigned LW = 27;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  mask;
        logic [15:0] wdata;
    } mem_txn_t;

    logic          clk = 1'b0;
    logic          reset_n, start, stop, direction;
    logic [31:0]   starting_address;
    logic [LW-1:0] transfer_length;
    logic          busy, rx_empty, rx_read, tx_full, tx_write;
    logic [7:0]    rx_rdata, tx_wdata;
    logic          mem_request, mem_ack, mem_write;
    logic [31:0]   mem_address;
    logic [1:0]    mem_wmask;
    logic [15:0]   mem_wdata, mem_rdata;

    int         n_tests, n_fail;
    logic [7:0] rx_q[$];
    logic [7:0] tx_exp[$];
    mem_txn_t   mem_exp[$];
    logic [15:0] rd_q[$];
    int         ack_delay, wait_cnt;
    logic       rx_pop_pend, prev_req, prev_ack, req_changed;
    mem_txn_t   held;
    int         req_cnt, ack_cnt, rx_cnt, tx_cnt, req_hi_cnt;

    memory_dma #(.LENGTH_WIDTH(LW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .direction(direction),
        .starting_address(starting_address), .transfer_length(transfer_length), .busy(busy),
        .rx_empty(rx_empty), .rx_read(rx_read), .rx_rdata(rx_rdata),
        .tx_full(tx_full), .tx_write(tx_write), .tx_wdata(tx_wdata),
        .mem_request(mem_request), .mem_ack(mem_ack), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_rx();
        rx_empty = (rx_q.size() == 0);
        rx_rdata = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    task automatic push_mem(input logic [31:0] a, input logic w, input logic [1:0] m, input logic [15:0] d);
        mem_txn_t t;
        t = {a, w, m, d};
        mem_exp.push_back(t);
    endtask

    // Mid-cycle observation of DUT outputs.
    task automatic monitor();
        mem_txn_t cur, e;
        logic [7:0] eb;
        cur = {mem_address, mem_write, mem_wmask, mem_wdata};
        if (prev_ack) check("req_gap", 32'(mem_request), 32'd0);
        if (mem_request && !prev_req) begin
            held = cur;
            req_changed = 1'b0;
            req_cnt++;
            req_hi_cnt = 0;
        end
        if (mem_request) begin
            req_hi_cnt++;
            if (cur !== held) req_changed = 1'b1;
        end
        if (rx_read) begin
            check("rx_read_when_empty", 32'(rx_empty), 32'd0);
            rx_pop_pend = 1'b1;
            rx_cnt++;
        end
        if (tx_write) begin
            tx_cnt++;
            check("tx_write_when_full", 32'(tx_full), 32'd0);
            if (tx_exp.size() != 0) eb = tx_exp.pop_front();
            else eb = 'x;
            check("tx_wdata", 32'(tx_wdata), 32'(eb));
        end
        if (mem_request && mem_ack) begin
            ack_cnt++;
            check("req_stable", 32'(req_changed), 32'd0);
            if (mem_exp.size() != 0) e = mem_exp.pop_front();
            else e = 'x;
            check("mem_address", mem_address, e.addr);
            check("mem_write", 32'(mem_write), 32'(e.wr));
            check("mem_wmask", 32'(mem_wmask), 32'(e.mask));
            if (e.wr === 1'b1) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
        prev_ack = mem_request && mem_ack;
        prev_req = mem_request;
    endtask

    // FIFO pop and memory responder, applied just after the active edge.
    task automatic service();
        if (rx_pop_pend && rx_q.size() != 0) rx_q.delete(0);
        rx_pop_pend = 1'b0;
        refresh_rx();
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_request) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hDEAD;
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        service();
    endtask

    task automatic start_xfer(input logic dir, input logic [31:0] a, input int len, input logic with_stop);
        direction        = dir;
        starting_address = a;
        transfer_length  = LW'(len);
        start            = 1'b1;
        stop             = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_request(input int max_cycles);
        int n;
        n = 0;
        while (mem_request !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check("request_timeout", 32'(mem_request), 32'd1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_mem_left"}, 32'(mem_exp.size()), 32'd0);
        check({tag, "_tx_left"}, 32'(tx_exp.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rx_read"}, 32'(rx_read), 32'd0);
        check({tag, "_tx_write"}, 32'(tx_write), 32'd0);
        check({tag, "_mem_request"}, 32'(mem_request), 32'd0);
        check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        check({tag, "_mem_address"}, mem_address, 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_tx_wdata"}, 32'(tx_wdata), 32'd0);
        check({tag, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
    endtask

    initial begin
        int base, base2, n;
        n_tests = 0; n_fail = 0;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; direction = 1'b0;
        starting_address = '0; transfer_length = '0;
        tx_full = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        ack_delay = 0; wait_cnt = 0; rx_pop_pend = 1'b0;
        prev_req = 1'b0; prev_ack = 1'b0; req_changed = 1'b0; held = '0;
        req_cnt = 0; ack_cnt = 0; rx_cnt = 0; tx_cnt = 0; req_hi_cnt = 0;
        refresh_rx();

        #12;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // stop in IDLE is ignored
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("stop_idle_busy", 32'(busy), 32'd0);

        // aligned write, with a start pulse while busy that must be ignored
        base = req_cnt;
        rx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        refresh_rx();
        push_mem(32'h0100_0000, 1'b1, 2'b11, 16'h1122);
        push_mem(32'h0100_0002, 1'b1, 2'b11, 16'h3344);
        start_xfer(1'b0, 32'h0100_0000, 4, 1'b0);
        tick();
        tick();
        direction = 1'b1; starting_address = 32'h0F00_0000; transfer_length = LW'(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(200);
        tick();
        check("wr_aligned_no_restart", 32'(busy), 32'd0);
        check("wr_aligned_req_cnt", 32'(req_cnt - base), 32'd2);
        check("wr_aligned_rx_left", 32'(rx_q.size()), 32'd0);
        check_drained("wr_aligned");

        // odd start address, single-byte lanes
        rx_q = '{8'hAA, 8'hBB};
        refresh_rx();
        push_mem(32'h0100_0000, 1'b1, 2'b01, 16'h00AA);
        push_mem(32'h0100_0002, 1'b1, 2'b10, 16'hBB00);
        start_xfer(1'b0, 32'h0100_0001, 2, 1'b0);
        wait_idle(200);
        check_drained("wr_odd");

        // odd-address read
        rd_q = '{16'h1234, 16'h5678};
        push_mem(32'h0100_0000, 1'b0, 2'b11, 16'h0000);
        push_mem(32'h0100_0002, 1'b0, 2'b11, 16'h0000);
        tx_exp = '{8'h34, 8'h56, 8'h78};
        start_xfer(1'b1, 32'h0100_0001, 3, 1'b0);
        wait_idle(200);
        check_drained("rd_odd");

        // read with tx back-pressure in the middle of a word
        rd_q = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
        push_mem(32'h0200_0000, 1'b0, 2'b11, 16'h0000);
        push_mem(32'h0200_0002, 1'b0, 2'b11, 16'h0000);
        push_mem(32'h0200_0004, 1'b0, 2'b11, 16'h0000);
        tx_exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        base = tx_cnt;
        start_xfer(1'b1, 32'h0200_0000, 6, 1'b0);
        n = 0;
        while (tx_cnt == base && n < 50) begin
            tick();
            n++;
        end
        check("bp_first_byte", 32'(tx_cnt - base), 32'd1);
        tx_full = 1'b1;
        base2 = tx_cnt;
        repeat (10) begin
            tick();
            check("bp_busy_while_full", 32'(busy), 32'd1);
        end
        check("bp_no_write_while_full", 32'(tx_cnt - base2), 32'd0);
        tx_full = 1'b0;
        wait_idle(200);
        check_drained("bp");

        // stop while the request is outstanding, ack delayed
        ack_delay = 5;
        rd_q = '{16'h9999};
        push_mem(32'h0300_0000, 1'b0, 2'b11, 16'h0000);
        base = tx_cnt;
        start_xfer(1'b1, 32'h0300_0000, 2, 1'b0);
        wait_request(20);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        base2 = ack_cnt;
        n = 0;
        while (ack_cnt == base2 && n < 30) begin
            tick();
            n++;
        end
        check("abort_ack_seen", 32'(ack_cnt - base2), 32'd1);
        check("abort_busy_after_ack", 32'(busy), 32'd0);
        check("abort_req_after_ack", 32'(mem_request), 32'd0);
        check("abort_req_held_cycles", 32'(req_hi_cnt), 32'd6);
        check("abort_no_tx", 32'(tx_cnt - base), 32'd0);
        ack_delay = 0;
        tick();
        check_drained("abort");

        // address wrap, start and stop together in IDLE
        rx_q = '{8'h01, 8'h02, 8'h03};
        refresh_rx();
        push_mem(32'hFFFF_FFFE, 1'b1, 2'b01, 16'h0001);
        push_mem(32'h0000_0000, 1'b1, 2'b11, 16'h0203);
        start_xfer(1'b0, 32'hFFFF_FFFF, 3, 1'b1);
        wait_idle(200);
        check_drained("wrap");

        // reset mid-GATHER, then a zero-length transfer
        rx_q = '{8'h55};
        refresh_rx();
        start_xfer(1'b0, 32'h0400_0000, 4, 1'b0);
        repeat (4) tick();
        check("gather_stall_busy", 32'(busy), 32'd1);
        check("gather_stall_popped", 32'(rx_q.size()), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_gather");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rx_q.delete();
        refresh_rx();
        tick();
        check("after_reset_idle", 32'(busy), 32'd0);
        base = req_cnt;
        base2 = rx_cnt;
        start_xfer(1'b0, 32'h0400_0000, 0, 1'b0);
        tick();
        check("len0_busy_one_cycle", 32'(busy), 32'd0);
        tick();
        check("len0_still_idle", 32'(busy), 32'd0);
        check("len0_no_request", 32'(req_cnt - base), 32'd0);
        check("len0_no_rx_read", 32'(rx_cnt - base2), 32'd0);

        // reset while a request is outstanding drops it at once
        ack_delay = 50;
        start_xfer(1'b1, 32'h0500_0000, 2, 1'b0);
        wait_request(20);
        base = req_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_req_async_drop", 32'(mem_request), 32'd0);
        check("rst_req_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ack_delay = 0;
        repeat (3) tick();
        check("rst_no_resume_busy", 32'(busy), 32'd0);
        check("rst_no_resume_req", 32'(req_cnt - base), 32'd0);
        check_drained("rst_req");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
